// File: rtl/rv_pkg.sv
// rv_pkg: shared RISC-V core types and constants used by the fetch stage.
package rv_pkg;
  localparam int XLEN = 32;
  localparam logic [31:0] RV_NOP = 32'h00000013;
  localparam logic [1:0] WORD_OFF_MASK = 2'b11;
  typedef enum logic [1:0] {FETCH_IDLE, FETCH_RUN, FETCH_FAULT} fetch_state_e;
endpackage

// File: rtl/imem_array.sv
// imem_array: word-organised instruction store, one write port, registered read port.
module imem_array #(
  parameter int DEPTH_WORDS = 64,
  parameter int AW = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [31:0]   wdata_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output logic [31:0]   rdata_o
);
  logic [31:0] mem_q [DEPTH_WORDS];
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    if (re_i) rdata_o <= mem_q[raddr_i];
  end
endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: owns the PC and instruction memory, streams {pc, instr} to decode
// with one-cycle redirect and a sticky fault on misaligned/out-of-range fetches.
module instr_fetch_unit
  import rv_pkg::*;
#(
  parameter int XLEN = rv_pkg::XLEN,
  parameter int DEPTH_WORDS = 64,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           load_en,
  input  logic [$clog2(DEPTH_WORDS)-1:0] load_addr,
  input  logic [31:0]                    load_data,
  input  logic                           run,
  input  logic                           redirect_valid,
  input  logic [XLEN-1:0]                redirect_pc,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [XLEN-1:0]                out_pc,
  output logic [31:0]                    out_instr,
  output logic                           fault
);
  localparam int AW = $clog2(DEPTH_WORDS);
  fetch_state_e    state_q;
  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] out_pc_q;
  logic            out_valid_q;
  logic            fault_q;
  logic            primed_q;
  logic [31:0]     rdata;
  logic            legal;
  logic            slot_free;
  logic            fetch;
  assign legal = ((pc_q[1:0] & WORD_OFF_MASK) == 2'b00) && ((pc_q >> (AW + 2)) == '0);
  assign slot_free = !out_valid_q || out_ready;
  assign fetch = (state_q == FETCH_RUN) && run && !redirect_valid && slot_free && legal;
  imem_array #(.DEPTH_WORDS(DEPTH_WORDS)) u_imem (
    .clk     (clk),
    .we_i    (load_en && (state_q == FETCH_IDLE)),
    .waddr_i (load_addr),
    .wdata_i (load_data),
    .re_i    (fetch),
    .raddr_i (pc_q[AW+1:2]),
    .rdata_o (rdata)
  );
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= FETCH_IDLE;
      pc_q        <= RESET_PC;
      out_pc_q    <= '0;
      out_valid_q <= 1'b0;
      fault_q     <= 1'b0;
      primed_q    <= 1'b0;
    end else begin
      case (state_q)
        FETCH_IDLE: begin
          if (redirect_valid) pc_q <= redirect_pc;
          if (run) state_q <= FETCH_RUN;
        end
        FETCH_RUN: begin
          if (redirect_valid || !run) begin
            out_valid_q <= 1'b0;
            if (redirect_valid) pc_q <= redirect_pc;
            if (!run) state_q <= FETCH_IDLE;
          end else if (slot_free) begin
            if (legal) begin
              out_pc_q    <= pc_q;
              out_valid_q <= 1'b1;
              pc_q        <= pc_q + XLEN'(4);
              primed_q    <= 1'b1;
            end else begin
              state_q     <= FETCH_FAULT;
              fault_q     <= 1'b1;
              out_valid_q <= 1'b0;
            end
          end
        end
        FETCH_FAULT: begin
          if (redirect_valid) begin
            pc_q    <= redirect_pc;
            fault_q <= 1'b0;
            state_q <= run ? FETCH_RUN : FETCH_IDLE;
          end
        end
        default: state_q <= FETCH_IDLE;
      endcase
    end
  end
  // The read register has no reset, so hide its stale contents until a real fetch lands.
  assign out_instr = primed_q ? rdata : '0;
  assign out_pc    = out_pc_q;
  assign out_valid = out_valid_q;
  assign fault     = fault_q;
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: directed scenarios plus randomized traffic against a
// transaction-level model (expected next pc + memory image).
module tb_instr_fetch_unit;
  localparam int D = 8;
  localparam int AW = $clog2(D);
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic load_en = 1'b0;
  logic [AW-1:0] load_addr = '0;
  logic [31:0] load_data = '0;
  logic run = 1'b0;
  logic redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic out_valid;
  logic out_ready = 1'b0;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic fault;
  logic [31:0] mdl [D];
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  instr_fetch_unit #(.XLEN(32), .DEPTH_WORDS(D), .RESET_PC(32'h0)) dut (
    .clk            (clk),
    .reset          (reset),
    .load_en        (load_en),
    .load_addr      (load_addr),
    .load_data      (load_data),
    .run            (run),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_pc         (out_pc),
    .out_instr      (out_instr),
    .fault          (fault)
  );
  function automatic bit legal(input logic [31:0] p);
    return (p[1:0] == 2'b00) && ((p >> 2) < D);
  endfunction
  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask
  task automatic load_program;
    for (int i = 0; i < D; i++) begin
      load_en = 1'b1;
      load_addr = AW'(i);
      load_data = mdl[i];
      tick;
    end
    load_en = 1'b0;
  endtask
  task automatic test_reset;
    repeat (2) @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || fault !== 1'b0 || out_pc !== 32'h0 || out_instr !== 32'h0) begin
      errors++;
      $display("FAIL reset_state: valid=%b fault=%b pc=%h instr=%h, required 0 0 0 0", out_valid, fault, out_pc, out_instr);
    end
    reset = 1'b1;
    tick;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL idle_no_output: valid=%b, required 0", out_valid);
    end
  endtask
  task automatic test_stream;
    run = 1'b1;
    out_ready = 1'b1;
    tick;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL stream_start_bubble: valid=%b, required 0", out_valid);
    end
    for (int i = 0; i < 4; i++) begin
      tick;
      checks++;
      if (out_valid !== 1'b1 || out_pc !== 32'(i * 4) || out_instr !== mdl[i]) begin
        errors++;
        $display("FAIL stream_%0d: valid=%b pc=%h instr=%h, required 1 %h %h", i, out_valid, out_pc, out_instr, 32'(i * 4), mdl[i]);
      end
    end
    run = 1'b0;
    tick;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL stop_flush: valid=%b, required 0", out_valid);
    end
    run = 1'b1;
    tick;
    tick;
    checks++;
    if (out_valid !== 1'b1 || out_pc !== 32'h10 || out_instr !== mdl[4]) begin
      errors++;
      $display("FAIL resume_no_rewind: valid=%b pc=%h instr=%h, required 1 00000010 %h", out_valid, out_pc, out_instr, mdl[4]);
    end
    run = 1'b0;
    tick;
  endtask
  task automatic test_backpressure;
    redirect_valid = 1'b1;
    redirect_pc = 32'h0;
    run = 1'b1;
    out_ready = 1'b1;
    tick;
    redirect_valid = 1'b0;
    tick;
    tick;
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (out_valid !== 1'b1 || out_pc !== 32'h4 || out_instr !== mdl[1]) begin
        errors++;
        $display("FAIL stall_%0d: valid=%b pc=%h instr=%h, required 1 00000004 %h", i, out_valid, out_pc, out_instr, mdl[1]);
      end
      if (i < 3) tick;
    end
    out_ready = 1'b1;
    for (int i = 2; i < 4; i++) begin
      tick;
      checks++;
      if (out_valid !== 1'b1 || out_pc !== 32'(i * 4) || out_instr !== mdl[i]) begin
        errors++;
        $display("FAIL release_%0d: valid=%b pc=%h instr=%h, required 1 %h %h", i, out_valid, out_pc, out_instr, 32'(i * 4), mdl[i]);
      end
    end
    run = 1'b0;
    tick;
  endtask
  task automatic test_redirect;
    redirect_valid = 1'b1;
    redirect_pc = 32'h0;
    run = 1'b1;
    out_ready = 1'b1;
    tick;
    redirect_valid = 1'b0;
    tick;
    redirect_valid = 1'b1;
    redirect_pc = 32'hC;
    tick;
    redirect_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || fault !== 1'b0) begin
      errors++;
      $display("FAIL redirect_bubble: valid=%b fault=%b, required 0 0", out_valid, fault);
    end
    for (int i = 3; i < 5; i++) begin
      tick;
      checks++;
      if (out_valid !== 1'b1 || out_pc !== 32'(i * 4) || out_instr !== mdl[i]) begin
        errors++;
        $display("FAIL redirect_target_%0d: valid=%b pc=%h instr=%h, required 1 %h %h", i, out_valid, out_pc, out_instr, 32'(i * 4), mdl[i]);
      end
    end
    run = 1'b0;
    tick;
  endtask
  task automatic test_fault;
    redirect_valid = 1'b1;
    redirect_pc = 32'h0;
    run = 1'b1;
    out_ready = 1'b1;
    tick;
    redirect_valid = 1'b1;
    redirect_pc = 32'h6;
    tick;
    redirect_valid = 1'b0;
    tick;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (fault !== 1'b1 || out_valid !== 1'b0) begin
        errors++;
        $display("FAIL misaligned_fault_%0d: fault=%b valid=%b, required 1 0", i, fault, out_valid);
      end
      tick;
    end
    redirect_valid = 1'b1;
    redirect_pc = 32'h4;
    tick;
    redirect_valid = 1'b0;
    checks++;
    if (fault !== 1'b0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL fault_clear: fault=%b valid=%b, required 0 0", fault, out_valid);
    end
    tick;
    checks++;
    if (out_valid !== 1'b1 || out_pc !== 32'h4 || out_instr !== mdl[1]) begin
      errors++;
      $display("FAIL fault_recover: valid=%b pc=%h instr=%h, required 1 00000004 %h", out_valid, out_pc, out_instr, mdl[1]);
    end
    run = 1'b0;
    tick;
  endtask
  task automatic test_end_of_memory;
    redirect_valid = 1'b1;
    redirect_pc = 32'h0;
    run = 1'b1;
    out_ready = 1'b1;
    tick;
    redirect_valid = 1'b0;
    load_en = 1'b1;
    load_addr = '0;
    load_data = ~mdl[0];
    for (int i = 0; i < D; i++) begin
      tick;
      checks++;
      if (out_valid !== 1'b1 || out_pc !== 32'(i * 4) || out_instr !== mdl[i]) begin
        errors++;
        $display("FAIL sweep_%0d: valid=%b pc=%h instr=%h, required 1 %h %h", i, out_valid, out_pc, out_instr, 32'(i * 4), mdl[i]);
      end
    end
    for (int i = 0; i < 3; i++) begin
      tick;
      checks++;
      if (fault !== 1'b1 || out_valid !== 1'b0) begin
        errors++;
        $display("FAIL end_fault_%0d: fault=%b valid=%b pc=%h, required fault 1 valid 0", i, fault, out_valid, out_pc);
      end
    end
    load_en = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc = 32'h0;
    run = 1'b0;
    tick;
    redirect_valid = 1'b0;
    checks++;
    if (fault !== 1'b0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL fault_to_idle: fault=%b valid=%b, required 0 0", fault, out_valid);
    end
  endtask
  task automatic test_async_reset;
    run = 1'b1;
    out_ready = 1'b1;
    repeat (3) tick;
    #2 reset = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || fault !== 1'b0 || out_pc !== 32'h0 || out_instr !== 32'h0) begin
      errors++;
      $display("FAIL async_reset: valid=%b fault=%b pc=%h instr=%h, required 0 0 0 0", out_valid, fault, out_pc, out_instr);
    end
    run = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    tick;
    run = 1'b1;
    tick;
    tick;
    checks++;
    if (out_valid !== 1'b1 || out_pc !== 32'h0 || out_instr !== mdl[0]) begin
      errors++;
      $display("FAIL retained_mem: valid=%b pc=%h instr=%h, required 1 00000000 %h", out_valid, out_pc, out_instr, mdl[0]);
    end
    run = 1'b0;
    tick;
  endtask
  task automatic test_random;
    logic [31:0] exp_pc;
    logic [31:0] tgt;
    int idle;
    for (int i = 0; i < D; i++) mdl[i] = $urandom;
    load_program;
    redirect_valid = 1'b1;
    redirect_pc = 32'h0;
    run = 1'b1;
    out_ready = 1'b1;
    exp_pc = 32'h0;
    idle = 0;
    tick;
    for (int n = 0; n < 600; n++) begin
      if (out_valid === 1'b1) begin
        checks++;
        if (!legal(exp_pc) || out_pc !== exp_pc || out_instr !== mdl[exp_pc[AW+1:2]]) begin
          errors++;
          $display("FAIL rand_out_%0d: pc=%h instr=%h, required pc %h instr %h", n, out_pc, out_instr, exp_pc, mdl[exp_pc[AW+1:2]]);
        end
      end
      if (fault === 1'b1) begin
        checks++;
        if (legal(exp_pc) || out_valid !== 1'b0) begin
          errors++;
          $display("FAIL rand_fault_%0d: fault=1 valid=%b at expected pc %h, required no fault", n, out_valid, exp_pc);
        end
      end
      idle = (out_valid === 1'b1 || fault === 1'b1) ? 0 : idle + 1;
      checks++;
      if (idle > 2) begin
        errors++;
        $display("FAIL rand_stall_%0d: %0d cycles without output or fault, required at most 2", n, idle);
      end
      tgt = 32'($urandom_range(0, D)) * 4;
      if ($urandom_range(0, 7) == 0) tgt = tgt + 32'd2;
      redirect_valid = (fault === 1'b1) || ($urandom_range(0, 9) == 0);
      redirect_pc = tgt;
      out_ready = ($urandom_range(0, 3) != 0);
      load_en = $urandom_range(0, 1) == 1;
      load_addr = AW'($urandom);
      load_data = $urandom;
      if (redirect_valid) begin
        exp_pc = tgt;
        idle = 0;
      end else if (out_valid === 1'b1 && out_ready) begin
        exp_pc = exp_pc + 32'd4;
      end
      tick;
    end
    load_en = 1'b0;
    redirect_valid = 1'b0;
    run = 1'b0;
    tick;
  endtask
  initial begin
    mdl[0] = 32'h00940333;
    mdl[1] = 32'h413903b3;
    mdl[2] = 32'h035a02b3;
    mdl[3] = 32'h017b4e33;
    for (int i = 4; i < D; i++) mdl[i] = $urandom;
    test_reset;
    load_program;
    test_stream;
    test_backpressure;
    test_redirect;
    test_fault;
    test_end_of_memory;
    test_async_reset;
    test_random;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Parametrised instruction fetch stage for the RISC-V core: owns the program counter and a word-organised instruction memory of configurable depth. Memory is loaded over a write port while idle. The unit then streams `{pc, instruction}` pairs to decode through a valid/ready handshake, with one-cycle redirect for branches and jumps. It also raises a sticky fault on misaligned or out-of-range PCs. It sits between the program loader/testbench and the decode stage, replacing the fixed 32-byte, reset-preloaded instruction store.

## Interface

- `XLEN`, 32, data/address width; only 32 supported.
- `DEPTH_WORDS`, 64, instruction memory depth in 32-bit words; power of two, ≥4.
- `RESET_PC`, 32'h0, PC value after reset; must be word-aligned.
- `clk`, in, 1, single clock; all state updates on the rising edge.
- `reset`, in, 1, asynchronous, active-low reset.
- `load_en`, in, 1, write `load_data` to word `load_addr`; honoured only in IDLE.
- `load_addr`, in, $clog2(DEPTH_WORDS), word index.
- `load_data`, in, 32, little-endian instruction word; bits [7:0] are byte 0.
- `run`, in, 1, level: fetch while high.
- `redirect_valid`, in, 1, branch/jump taken this cycle.
- `redirect_pc`, in, 32, byte address to fetch from next.
- `out_valid`, out, 1, `out_pc`/`out_instr` hold a valid fetch.
- `out_ready`, in, 1, decode accepts the current fetch.
- `out_pc`, out, 32, byte address of `out_instr`.
- `out_instr`, out, 32, fetched instruction word.
- `fault`, out, 1, fetch fault; sticky.

## Operation

- States: IDLE, FETCH, FAULT.
- Reset (reset=0, asynchronous) produces: state IDLE, pc=RESET_PC, out_valid=0, out_pc=0, out_instr=0, fault=0.
- Memory contents are not cleared by reset and survive it.
- IDLE:
  - `load_en` writes memory.
  - `run`=1 moves to FETCH.
  - `redirect_valid` updates pc.
- FETCH:
  - `load_en` is ignored.
  - If out register is empty or consumed (`!out_valid || out_ready`), the current pc is checked.
    - Legal pc (pc[1:0]==0 and pc[31:2] < DEPTH_WORDS): out_pc←pc, out_instr←mem[pc[..:2]], out_valid←1, pc←pc+4.
    - Illegal pc: go to FAULT; fault←1, out_valid←0, pc unchanged.
  - `run`=0: go to IDLE, out_valid←0, pc unchanged. The unconsumed fetch is discarded and pc is not rewound.
- Redirect (any state except FAULT priority rules below):
  - Has priority over a normal fetch: pc←redirect_pc, out_valid←0 (flush).
  - No fetch occurs in the redirect cycle.
- FAULT:
  - out_valid=0, fault=1.
  - `redirect_valid` sets pc←redirect_pc, clears fault, and returns to FETCH if `run`=1, else IDLE.
  - Otherwise held until reset.
- No wrap-around: a pc advancing past the last word faults on its next fetch attempt.
- Simultaneous `run` deassert and redirect: pc takes redirect_pc, state goes to IDLE.

## Timing

- Registered memory read; the out register is the only pipeline stage.
- `run` sampled high at edge k in IDLE puts the unit in FETCH after k. out_valid rises after edge k+1 with the instruction at RESET_PC.
- With `out_ready` held high: one instruction per cycle, consecutive pcs.
- Backpressure: while `out_valid && !out_ready`, out_pc, out_instr and pc are stable.
- Redirect sampled at edge k: out_valid=0 after k. The target instruction is valid after k+1, so there is a 1-bubble penalty.
- Fault is detected at the fetch-attempt edge; fault=1 after that edge.

## Structure

- Shared package `rv_pkg`:
  - `XLEN`
  - fetch FSM state enum (`FETCH_IDLE`, `FETCH_RUN`, `FETCH_FAULT`)
  - `RV_NOP` = 32'h00000013
  - alignment-check helper constant (word-offset mask 2'b11)
- Sub-module `imem_array`: DEPTH_WORDS×32 single write port, synchronous read port, no reset.
- FSM, pc register, out register and fault logic live in the top module.

## Test plan

- Load words 0–3 = 0x00940333, 0x413903b3, 0x035a02b3, 0x017b4e33; run=1, out_ready=1 → consecutive out pairs (0x0,0x00940333), (0x4,0x413903b3), (0x8,0x035a02b3), (0xC,0x017b4e33).
- Same program, out_ready=0 for 3 cycles at pc 0x4 → out_instr stays 0x413903b3; no skip or duplicate after release.
- Redirect to 0xC while (0x0,0x00940333) is valid → out_valid=0 for one cycle, then (0xC,0x017b4e33), then (0x10, word 4).
- Redirect to 0x6 → fault=1 and out_valid=0 next cycle. Redirect to 0x4 then clears fault and delivers 0x413903b3.
- DEPTH_WORDS=8, run from 0x0 with ready=1 → eight words for 0x0–0x1C, then fault=1 at pc 0x20, with no wrap to 0x0.
- Assert reset low mid-stream (asynchronous, between edges) → out_valid, fault and out_pc go to 0 immediately. After release and run=1, the first output is (RESET_PC, the previously loaded word 0), with memory retained.
